mux_pipe_n: RTL and testbench

Parametrised, pipelined m-to-1 n-bit multiplexer, successor to the combinational wide mux trees in `library/`. It is built as a tree of radix-4 levels, with a register after every level, so it closes timing at large widths and depths. A per-beat valid bit travels with each selection, and the pipeline supports synchronous stall and flush. It is used wherever register-file or lookup-table read selection must be registered, for example in pipelined register-file read ports and in table reads.

---
 rtl/mux_pipe_n.sv | 80 ++++++++
 tb/tb_mux_pipe_n.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_n.sv
// Pipelined m-to-1 n-bit multiplexer: a tree of registered radix-4 levels (radix-2 for the last
// level when the select width is odd), with a valid bit per beat plus stall and flush control.
module mux_pipe_n #(
   parameter int unsigned n       = 4,
   parameter int unsigned address = 9,
   parameter int unsigned m       = 2 ** address
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [n-1:0]       data_i [0:m-1],
   input  logic [address-1:0] sel,
   input  logic               valid_i,
   input  logic               stall_i,
   input  logic               flush_i,
   output logic [n-1:0]       data_o,
   output logic               valid_o
);
   localparam int unsigned L = (address + 1) / 2;

   for (genvar k = 0; k < L; k++) begin : g_lvl
      // SrcSelW: select bits still unresolved on entry to this level.
      localparam int unsigned SrcSelW = address - 2 * k;
      localparam int unsigned Bits    = (SrcSelW >= 2) ? 2 : 1;
      localparam int unsigned Radix   = 2 ** Bits;
      localparam int unsigned SrcCnt  = 2 ** SrcSelW;
      localparam int unsigned OutCnt  = 2 ** (SrcSelW - Bits);

      logic [n-1:0]       src [SrcCnt];
      logic [SrcSelW-1:0] src_sel;
      logic               src_valid;
      logic [n-1:0]       word_d [OutCnt];
      logic [n-1:0]       word_q [OutCnt];
      logic               valid_q;

      if (k == 0) begin : g_src
         assign src       = data_i;
         assign src_sel   = sel;
         assign src_valid = valid_i;
      end else begin : g_src
         assign src       = g_lvl[k-1].word_q;
         assign src_sel   = g_lvl[k-1].g_sel.sel_q;
         assign src_valid = g_lvl[k-1].valid_q;
      end

      // Low select bits pick one word out of each group of Radix neighbours.
      always_comb begin
         for (int unsigned i = 0; i < OutCnt; i++) begin
            word_d[i] = src[SrcSelW'(i * Radix) + SrcSelW'(src_sel[Bits-1:0])];
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            word_q  <= '{default: '0};
            valid_q <= 1'b0;
         end else if (flush_i) begin
            valid_q <= 1'b0;
         end else if (!stall_i) begin
            word_q  <= word_d;
            valid_q <= src_valid;
         end
      end

      if (k < L - 1) begin : g_sel
         logic [SrcSelW-Bits-1:0] sel_q;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               sel_q <= '0;
            end else if (!flush_i && !stall_i) begin
               sel_q <= src_sel[SrcSelW-1:Bits];
            end
         end
      end
   end

   assign data_o  = g_lvl[L-1].word_q[0];
   assign valid_o = g_lvl[L-1].valid_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed, table-driven bench for mux_pipe_n: default geometry plus a small parameter sweep.
module tb_mux_pipe_n;

   typedef struct {
      logic [8:0] sl;
      logic [3:0] exp;
   } vec_t;

   typedef struct {
      logic       vin;
      logic [8:0] sl;
      logic       st;
      logic       fl;
      logic       ev;
      logic [3:0] ed;
   } seq_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  d9 [0:511];
   logic [8:0]  s9;
   logic        v9, st9, fl9, vq9;
   logic [3:0]  q9;
   logic [15:0] d1 [0:1];
   logic [0:0]  s1;
   logic        v1, vq1;
   logic [15:0] q1;
   logic [3:0]  d2 [0:3];
   logic [1:0]  s2;
   logic        v2, vq2;
   logic [3:0]  q2;
   logic [3:0]  d3 [0:7];
   logic [2:0]  s3;
   logic        v3, vq3;
   logic [3:0]  q3;
   logic [15:0] d10 [0:1023];
   logic [9:0]  s10;
   logic        v10, vq10;
   logic [15:0] q10;

   int   n_cmp = 0;
   int   n_bad = 0;
   seq_t seq_q [$];

   mux_pipe_n #(.n(4), .address(9)) u_dut (
      .clk_i(clk), .rst_i(rst), .data_i(d9), .sel(s9), .valid_i(v9),
      .stall_i(st9), .flush_i(fl9), .data_o(q9), .valid_o(vq9)
   );
   mux_pipe_n #(.n(16), .address(1)) u_a1 (
      .clk_i(clk), .rst_i(rst), .data_i(d1), .sel(s1), .valid_i(v1),
      .stall_i(1'b0), .flush_i(1'b0), .data_o(q1), .valid_o(vq1)
   );
   mux_pipe_n #(.n(4), .address(2)) u_a2 (
      .clk_i(clk), .rst_i(rst), .data_i(d2), .sel(s2), .valid_i(v2),
      .stall_i(1'b0), .flush_i(1'b0), .data_o(q2), .valid_o(vq2)
   );
   mux_pipe_n #(.n(4), .address(3)) u_a3 (
      .clk_i(clk), .rst_i(rst), .data_i(d3), .sel(s3), .valid_i(v3),
      .stall_i(1'b0), .flush_i(1'b0), .data_o(q3), .valid_o(vq3)
   );
   mux_pipe_n #(.n(16), .address(10)) u_a10 (
      .clk_i(clk), .rst_i(rst), .data_i(d10), .sel(s10), .valid_i(v10),
      .stall_i(1'b0), .flush_i(1'b0), .data_o(q10), .valid_o(vq10)
   );

   function automatic logic [3:0] model(input logic [8:0] j);
      return j[3:0] ^ j[7:4];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      v9 = 1'b0;
      repeat (cycles) tick();
   endtask

   task automatic add(input logic vin, input logic [8:0] sl, input logic st, input logic fl,
                      input logic ev, input logic [3:0] ed);
      seq_t e;
      e.vin = vin;
      e.sl  = sl;
      e.st  = st;
      e.fl  = fl;
      e.ev  = ev;
      e.ed  = ed;
      seq_q.push_back(e);
   endtask

   task automatic run_seq(input string name);
      foreach (seq_q[i]) begin
         v9  = seq_q[i].vin;
         s9  = seq_q[i].sl;
         st9 = seq_q[i].st;
         fl9 = seq_q[i].fl;
         tick();
         check({name, "_valid"}, 32'(vq9), 32'(seq_q[i].ev));
         if (seq_q[i].ev) check({name, "_data"}, 32'(q9), 32'(seq_q[i].ed));
      end
      seq_q.delete();
      v9  = 1'b0;
      st9 = 1'b0;
      fl9 = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "bench did not terminate");
   end

   initial begin
      vec_t       tab [12];
      logic [9:0] r10 [20];
      tab = '{'{9'h000, 4'h0}, '{9'h001, 4'h1}, '{9'h00F, 4'hF}, '{9'h010, 4'h1},
              '{9'h011, 4'h0}, '{9'h0FF, 4'h0}, '{9'h1FF, 4'h0}, '{9'h1A5, 4'hF},
              '{9'h12C, 4'hE}, '{9'h0A3, 4'h9}, '{9'h137, 4'h4}, '{9'h1C8, 4'h4}};

      rst = 1'b1;
      {v9, st9, fl9, v1, v2, v3, v10} = '0;
      s9 = '0; s1 = '0; s2 = '0; s3 = '0; s10 = '0;
      for (int j = 0; j < 512; j++) d9[j] = model(9'(j));
      for (int j = 0; j < 1024; j++) d10[j] = 16'(j);
      d1 = '{16'hAAAA, 16'h5555};
      d2 = '{4'h3, 4'h4, 4'h5, 4'h6};
      for (int j = 0; j < 8; j++) d3[j] = 4'(j) ^ 4'h9;

      // Reset is visible before any clock edge.
      #2;
      check("reset_valid", 32'(vq9), 0);
      check("reset_data", 32'(q9), 0);
      tick();
      rst = 1'b0;

      // First beat after reset, latency 5.
      v9 = 1'b1;
      s9 = 9'd300;
      for (int i = 1; i <= 5; i++) begin
         tick();
         v9 = 1'b0;
         check("first_valid", 32'(vq9), (i == 5) ? 1 : 0);
         if (i == 5) check("first_data", 32'(q9), 32'h0E);
      end

      // Table vectors, back to back.
      for (int c = 0; c < 16; c++) begin
         v9 = (c < 12);
         if (c < 12) s9 = tab[c].sl;
         tick();
         if (c >= 4) begin
            check("table_valid", 32'(vq9), 1);
            check("table_data", 32'(q9), 32'(tab[c-4].exp));
         end
      end
      idle(5);

      // Full stream; data_i is re-keyed every cycle, so each beat must use its own sample.
      for (int c = 0; c < 517; c++) begin
         if (c < 512) begin
            for (int j = 0; j < 512; j++) d9[j] = model(9'(j)) ^ 4'(c);
            v9 = 1'b1;
            s9 = 9'(c);
         end else begin
            v9 = 1'b0;
         end
         tick();
         if (c >= 4 && c < 516) begin
            check("stream_valid", 32'(vq9), 1);
            check("stream_data", 32'(q9), 32'(model(9'(c - 4)) ^ 4'(c - 4)));
         end else begin
            check("stream_valid", 32'(vq9), 0);
         end
      end
      for (int j = 0; j < 512; j++) d9[j] = model(9'(j));

      // Stall for 3 cycles; valid_i during stall is dropped.
      add(1, 9'd10, 0, 0, 0, 4'h0);
      add(1, 9'd11, 0, 0, 0, 4'h0);
      add(1, 9'd12, 0, 0, 0, 4'h0);
      add(1, 9'd13, 0, 0, 0, 4'h0);
      add(0, 9'd0, 0, 0, 1, 4'hA);
      add(0, 9'd0, 0, 0, 1, 4'hB);
      for (int i = 0; i < 3; i++) add(1, 9'd300, 1, 0, 1, 4'hB);
      add(0, 9'd0, 0, 0, 1, 4'hC);
      add(0, 9'd0, 0, 0, 1, 4'hD);
      for (int i = 0; i < 3; i++) add(0, 9'd0, 0, 0, 0, 4'h0);
      run_seq("stall");

      // Flush on the 4th beat, later flush together with stall.
      for (int i = 0; i < 5; i++) add(1, 9'(20 + i), 0, (i == 3), 0, 4'h0);
      for (int i = 0; i < 3; i++) add(0, 9'd0, 0, 0, 0, 4'h0);
      add(0, 9'd0, 0, 0, 1, 4'h9);
      add(1, 9'd25, 0, 0, 0, 4'h0);
      add(1, 9'd26, 0, 0, 0, 4'h0);
      add(1, 9'd27, 1, 1, 0, 4'h0);
      add(1, 9'd28, 0, 0, 0, 4'h0);
      for (int i = 0; i < 3; i++) add(0, 9'd0, 0, 0, 0, 4'h0);
      add(0, 9'd0, 0, 0, 1, 4'hD);
      add(0, 9'd0, 0, 0, 0, 4'h0);
      run_seq("flush");

      // Mid-stream reset with beats in flight.
      for (int c = 0; c < 6; c++) begin
         v9 = 1'b1;
         s9 = 9'(40 + c);
         tick();
      end
      v9 = 1'b0;
      check("pre_reset_valid", 32'(vq9), 1);
      check("pre_reset_data", 32'(q9), 32'hB);
      #2 rst = 1'b1;
      #1;
      check("async_reset_valid", 32'(vq9), 0);
      check("async_reset_data", 32'(q9), 0);
      #1 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("post_reset_valid", 32'(vq9), 0);
      end

      // address=1, L=1.
      check("a1_idle_valid", 32'(vq1), 0);
      v1 = 1'b1;
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      check("a1_valid", 32'(vq1), 1);
      check("a1_data_sel1", 32'(q1), 32'h5555);
      tick();
      v1 = 1'b0;
      check("a1_data_sel0", 32'(q1), 32'hAAAA);
      tick();
      check("a1_drain_valid", 32'(vq1), 0);

      // address=2, L=1.
      v2 = 1'b1;
      s2 = 2'd2;
      tick();
      v2 = 1'b0;
      check("a2_valid", 32'(vq2), 1);
      check("a2_data", 32'(q2), 32'h5);
      tick();
      check("a2_drain_valid", 32'(vq2), 0);

      // address=3, L=2.
      v3 = 1'b1;
      s3 = 3'd6;
      tick();
      v3 = 1'b0;
      check("a3_early_valid", 32'(vq3), 0);
      tick();
      check("a3_valid", 32'(vq3), 1);
      check("a3_data", 32'(q3), 32'hF);
      tick();
      check("a3_drain_valid", 32'(vq3), 0);

      // address=10, data_i[j]=j, random selects.
      for (int c = 0; c < 24; c++) begin
         if (c < 20) begin
            r10[c] = 10'($urandom_range(0, 1023));
            s10 = r10[c];
            v10 = 1'b1;
         end else begin
            v10 = 1'b0;
         end
         tick();
         if (c >= 4) begin
            check("a10_valid", 32'(vq10), 1);
            check("a10_data", 32'(q10), 32'(r10[c-4]));
         end
      end
      tick();
      check("a10_drain_valid", 32'(vq10), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
